fitness_wb_buffer: RTL and testbench
====================================

FITNESS_WB_BUFFER -- requirements
Module: fitness_wb_buffer

Interface
REQ-001 The block SHALL have parameter POP_SIZE, default 50, number of individuals per generation.
REQ-002 The block SHALL have parameter SELF_FIT_LENGTH, default 10, energy width in bits.
REQ-003 The block SHALL have parameter IDX_WIDTH, default 6, individual index width; POP_SIZE <= 2**IDX_WIDTH.
REQ-004 The block SHALL have clk_i  input  1  the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have start_i  input  1  begin a new generation.
REQ-007 The block SHALL have in_valid_i  input  1  energy sample valid, driven by upstream fitness_eval out_valid_ff_o.
REQ-008 The block SHALL have energy_i  input  SELF_FIT_LENGTH  total energy of one individual.
REQ-009 The block SHALL have ind_idx_i  input  IDX_WIDTH  index of that individual.
REQ-010 The block SHALL have rd_en_i  input  1  and rd_idx_i  input  IDX_WIDTH, the read request for selection logic.
REQ-011 The block SHALL have rd_data_ff_o  output  SELF_FIT_LENGTH  and rd_valid_ff_o  output  1, the registered read response.
REQ-012 The block SHALL have best_energy_ff_o  output  SELF_FIT_LENGTH  and best_idx_ff_o  output  IDX_WIDTH, the minimum energy so far and its index.
REQ-013 The block SHALL have count_ff_o  output  IDX_WIDTH+1  distinct individuals stored this generation.
REQ-014 The block SHALL have gen_done_ff_o  output  1  one-cycle pulse when the generation is complete.
REQ-015 The block SHALL have busy_ff_o  output  1  high while in COLLECT.
REQ-016 The block SHALL have err_ff_o  output  2  sticky flags: bit0 duplicate index, bit1 index out of range.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, COLLECT, DONE.
REQ-018 IDLE or DONE with start_i=1 SHALL go to COLLECT, clearing the per-index written bitmap, count_ff_o, and err_ff_o, and loading best_energy_ff_o with all-ones and best_idx_ff_o with 0.
REQ-019 start_i in COLLECT SHALL restart the generation exactly as in REQ-018; any in_valid_i sample in that cycle SHALL be dropped.
REQ-020 In COLLECT, in_valid_i=1 with ind_idx_i < POP_SIZE SHALL write energy_i into the fitness memory at ind_idx_i on that edge.
REQ-021 A first write to an index SHALL set its bitmap bit and increment count_ff_o by 1.
REQ-022 A repeat write to an already-written index SHALL overwrite the memory, leave count unchanged, and set err bit0.
REQ-023 A sample with ind_idx_i >= POP_SIZE SHALL be discarded and SHALL set err bit1.
REQ-024 An accepted sample with energy_i strictly less than best_energy_ff_o SHALL update best_energy_ff_o and best_idx_ff_o on the same edge; a tie SHALL keep the earlier index.
REQ-025 A duplicate write SHALL NOT re-evaluate best downward from the overwritten value; best remains the minimum of all accepted samples.
REQ-026 On the edge where count reaches POP_SIZE, the FSM SHALL enter DONE, pulse gen_done_ff_o for exactly one cycle, and busy_ff_o SHALL fall.
REQ-027 The best outputs on that edge SHALL include the final sample.
REQ-028 in_valid_i in IDLE or DONE SHALL be ignored, with no memory, count, or error change.
REQ-029 rd_en_i=1 in any state SHALL return memory[rd_idx_i] on rd_data_ff_o with rd_valid_ff_o=1 one cycle later.
REQ-030 rd_valid_ff_o SHALL be 0 in cycles following rd_en_i=0.
REQ-031 A read and a write to the same index in the same cycle SHALL return the old value.
REQ-032 A read of an unwritten index or of rd_idx_i >= POP_SIZE SHALL return 0 with rd_valid_ff_o=1.
REQ-033 Energy comparison SHALL be unsigned at SELF_FIT_LENGTH bits.

Reset
REQ-034 rst_i=1 at a rising edge SHALL force IDLE and clear the bitmap.
REQ-035 The reset values SHALL be: count_ff_o=0, err_ff_o=0, gen_done_ff_o=0, busy_ff_o=0, rd_valid_ff_o=0, rd_data_ff_o=0, best_energy_ff_o all-ones, best_idx_ff_o=0.
REQ-036 Reset SHALL take priority over start_i and in_valid_i; reset mid-COLLECT SHALL abandon the generation.
REQ-037 Reset SHALL NOT clear the memory contents; memory reads after reset SHALL return 0 via the bitmap rule of REQ-032.

Verification
REQ-038 Scenario: start, then 50 samples idx 0..49 with energy = 100-idx on consecutive cycles -> gen_done pulses once on the 50th edge, count=50, best_energy=51, best_idx=49, err=0.
REQ-039 Scenario: samples idx 3 energy 20 then idx 7 energy 20 -> best_idx=3 (tie keeps earlier).
REQ-040 Scenario: idx 5 written twice (30, then 10), then idx 60 -> count increments once, err=2'b11, rd idx 5 returns 10.
REQ-041 Scenario: rst_i asserted after 20 samples -> all outputs at reset values next cycle; a new start plus 50 samples completes normally.
REQ-042 Scenario: rd_en_i with idx 9 in the same cycle as write idx 9 energy 44 (old value 12) -> rd_data=12; repeating the read next cycle -> rd_data=44.
REQ-043 Scenario: in_valid_i pulses in DONE, and start_i with in_valid_i together -> sample ignored, count=0 after restart.

Source files
------------

// File: rtl/fitness_wb_buffer_if.sv
// Bus bundle between the fitness evaluator / selection logic and the fitness
// write-back buffer. Signal names keep the buffer's _i/_o direction suffixes.
interface fitness_wb_buffer_if #(
  parameter int SELF_FIT_LENGTH = 10,
  parameter int IDX_WIDTH       = 6
);
  // in_valid_i has no ready: the buffer is always able to take a sample, so a
  // sample is transferred on every rising edge where in_valid_i=1. Likewise a
  // read request (rd_en_i) is always taken and answered one cycle later with
  // rd_valid_ff_o=1.
  logic                       start_i;
  logic                       in_valid_i;
  logic [SELF_FIT_LENGTH-1:0] energy_i;
  logic [IDX_WIDTH-1:0]       ind_idx_i;
  logic                       rd_en_i;
  logic [IDX_WIDTH-1:0]       rd_idx_i;
  logic [SELF_FIT_LENGTH-1:0] rd_data_ff_o;
  logic                       rd_valid_ff_o;
  logic [SELF_FIT_LENGTH-1:0] best_energy_ff_o;
  logic [IDX_WIDTH-1:0]       best_idx_ff_o;
  logic [IDX_WIDTH:0]         count_ff_o;
  logic                       gen_done_ff_o;
  logic                       busy_ff_o;
  logic [1:0]                 err_ff_o;

  modport master (
    output start_i, in_valid_i, energy_i, ind_idx_i, rd_en_i, rd_idx_i,
    input  rd_data_ff_o, rd_valid_ff_o, best_energy_ff_o, best_idx_ff_o,
           count_ff_o, gen_done_ff_o, busy_ff_o, err_ff_o
  );

  modport slave (
    input  start_i, in_valid_i, energy_i, ind_idx_i, rd_en_i, rd_idx_i,
    output rd_data_ff_o, rd_valid_ff_o, best_energy_ff_o, best_idx_ff_o,
           count_ff_o, gen_done_ff_o, busy_ff_o, err_ff_o
  );
endinterface

// File: rtl/fitness_wb_buffer.sv
// Collects one energy value per individual for a generation, tracks the
// minimum-energy individual, and serves registered reads to selection logic.
module fitness_wb_buffer #(
  parameter int POP_SIZE        = 50,
  parameter int SELF_FIT_LENGTH = 10,
  parameter int IDX_WIDTH       = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  fitness_wb_buffer_if.slave     bus,
  output logic [1:0]             o_state_dbg
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH:0] LP_POP = (IDX_WIDTH+1)'(POP_SIZE);

  logic [SELF_FIT_LENGTH-1:0] r_mem [POP_SIZE];
  logic [POP_SIZE-1:0]        r_written;
  state_t                     r_state;
  logic [IDX_WIDTH:0]         r_count;
  logic [1:0]                 r_err;
  logic [SELF_FIT_LENGTH-1:0] r_best;
  logic [IDX_WIDTH-1:0]       r_best_idx;
  logic                       r_gen_done;
  logic                       r_busy;
  logic                       r_rd_valid;
  logic [SELF_FIT_LENGTH-1:0] r_rd_data;

  logic w_in_range;
  logic w_rd_range;
  logic w_accept;
  logic w_dup;
  logic w_better;

  assign w_in_range = ({1'b0, bus.ind_idx_i} < LP_POP);
  assign w_rd_range = ({1'b0, bus.rd_idx_i} < LP_POP);
  // A start in the same cycle wins over the sample, which is dropped.
  assign w_accept   = !rst_i && (r_state == S_COLLECT) && bus.in_valid_i &&
                      !bus.start_i && w_in_range;
  assign w_dup      = w_accept && r_written[bus.ind_idx_i];
  assign w_better   = w_accept && (bus.energy_i < r_best);

  // Memory has no reset; the written bitmap hides stale contents.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_mem[bus.ind_idx_i] <= bus.energy_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_written  <= '0;
      r_count    <= '0;
      r_err      <= '0;
      r_best     <= '1;
      r_best_idx <= '0;
      r_gen_done <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.rd_en_i;
      if (bus.rd_en_i)
        r_rd_data <= (w_rd_range && r_written[bus.rd_idx_i]) ? r_mem[bus.rd_idx_i] : '0;
      r_gen_done <= 1'b0;

      if (bus.start_i) begin
        r_state    <= S_COLLECT;
        r_written  <= '0;
        r_count    <= '0;
        r_err      <= '0;
        r_best     <= '1;
        r_best_idx <= '0;
        r_busy     <= 1'b1;
      end else if (r_state == S_COLLECT && bus.in_valid_i) begin
        if (!w_in_range) begin
          r_err[1] <= 1'b1;
        end else begin
          r_written[bus.ind_idx_i] <= 1'b1;
          if (w_dup) begin
            r_err[0] <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
            if (r_count + 1'b1 == LP_POP) begin
              r_state    <= S_DONE;
              r_gen_done <= 1'b1;
              r_busy     <= 1'b0;
            end
          end
          // Strict less-than: a tie keeps the earlier index.
          if (w_better) begin
            r_best     <= bus.energy_i;
            r_best_idx <= bus.ind_idx_i;
          end
        end
      end
    end
  end

  assign bus.rd_data_ff_o     = r_rd_data;
  assign bus.rd_valid_ff_o    = r_rd_valid;
  assign bus.best_energy_ff_o = r_best;
  assign bus.best_idx_ff_o    = r_best_idx;
  assign bus.count_ff_o       = r_count;
  assign bus.gen_done_ff_o    = r_gen_done;
  assign bus.busy_ff_o        = r_busy;
  assign bus.err_ff_o         = r_err;
  assign o_state_dbg          = r_state;
endmodule

// File: tb/tb_fitness_wb_buffer.sv
// Bench for fitness_wb_buffer: directed scenarios plus random traffic, checked
// every cycle against a set/map based model of one generation.
module tb_fitness_wb_buffer;
  localparam int POP = 50;
  localparam int W   = 10;
  localparam int IW  = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fitness_wb_buffer_if #(.SELF_FIT_LENGTH(W), .IDX_WIDTH(IW)) bus ();
  logic [1:0] state_dbg;

  fitness_wb_buffer #(.POP_SIZE(POP), .SELF_FIT_LENGTH(W), .IDX_WIDTH(IW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .o_state_dbg (state_dbg)
  );

  // ---------------- model ----------------
  // m_set: indices accepted this generation; m_mem: last value ever stored per index.
  int             m_set [int];
  int             m_mem [int];
  int             m_phase;      // 0 idle, 1 collecting, 2 done
  logic [W-1:0]   m_best;
  int             m_bidx;
  logic [1:0]     m_err;
  logic           m_done;
  logic           m_rd_valid;
  logic [W-1:0]   exp_q [$];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  done_seen = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic st, input logic v, input int e, input int idx,
                            input logic re, input int ridx, input logic rs);
    logic [W-1:0] ev;
    ev = W'(e);
    if (rs) begin
      m_set.delete();
      m_phase = 0; m_best = '1; m_bidx = 0; m_err = 0; m_done = 0; m_rd_valid = 0;
      return;
    end
    m_rd_valid = re;
    if (re) exp_q.push_back((ridx < POP && m_set.exists(ridx)) ? W'(m_mem[ridx]) : '0);
    m_done = 0;
    if (st) begin
      m_set.delete();
      m_phase = 1; m_best = '1; m_bidx = 0; m_err = 0;
    end else if (m_phase == 1 && v) begin
      if (idx >= POP) m_err[1] = 1'b1;
      else begin
        if (m_set.exists(idx)) m_err[0] = 1'b1;
        m_set[idx] = 1;
        m_mem[idx] = ev;
        if (ev < m_best) begin m_best = ev; m_bidx = idx; end
        if (m_set.num() == POP) begin m_phase = 2; m_done = 1; end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic st, input logic v, input int e, input int idx,
                       input logic re, input int ridx, input logic rs);
    rst            = rs;
    bus.start_i    = st;
    bus.in_valid_i = v;
    bus.energy_i   = W'(e);
    bus.ind_idx_i  = IW'(idx);
    bus.rd_en_i    = re;
    bus.rd_idx_i   = IW'(ridx);
    model_step(st, v, e, idx, re, ridx, rs);
    chk_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();                       drive(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic sample(input int i, input int e); drive(0, 1, e, i, 0, 0, 0); endtask
  task automatic rd(input int i);              drive(0, 0, 0, 0, 1, i, 0); endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(bus.count_ff_o), 0);
    chk({tag, "_err"}, 32'(bus.err_ff_o), 0);
    chk({tag, "_best"}, 32'(bus.best_energy_ff_o), 1023);
    chk({tag, "_bidx"}, 32'(bus.best_idx_ff_o), 0);
    chk({tag, "_done"}, 32'(bus.gen_done_ff_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_ff_o), 0);
    chk({tag, "_rdv"}, 32'(bus.rd_valid_ff_o), 0);
    chk({tag, "_rdd"}, 32'(bus.rd_data_ff_o), 0);
  endtask

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("count", 32'(bus.count_ff_o), 32'(m_set.num()));
      chk("err", 32'(bus.err_ff_o), 32'(m_err));
      chk("best_energy", 32'(bus.best_energy_ff_o), 32'(m_best));
      chk("best_idx", 32'(bus.best_idx_ff_o), 32'(m_bidx));
      chk("gen_done", 32'(bus.gen_done_ff_o), 32'(m_done));
      chk("busy", 32'(bus.busy_ff_o), 32'(m_phase == 1));
      chk("state_dbg", 32'(state_dbg), 32'(m_phase));
      chk("rd_valid", 32'(bus.rd_valid_ff_o), 32'(m_rd_valid));
      if (m_rd_valid && exp_q.size() > 0) chk("rd_data", 32'(bus.rd_data_ff_o), 32'(exp_q.pop_front()));
      if (bus.gen_done_ff_o === 1'b1) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 7, 3, 1, 3, 1);
    chk_reset_vals("rst");

    // Full generation, energy = 100 - idx.
    d0 = done_seen;
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < POP; i++) sample(i, 100 - i);
    chk("g1_count", 32'(bus.count_ff_o), 50);
    chk("g1_best", 32'(bus.best_energy_ff_o), 51);
    chk("g1_bidx", 32'(bus.best_idx_ff_o), 49);
    chk("g1_err", 32'(bus.err_ff_o), 0);
    chk("g1_done", 32'(bus.gen_done_ff_o), 1);
    chk("g1_busy", 32'(bus.busy_ff_o), 0);
    sample(3, 1);
    chk("g1_done_once", 32'(done_seen - d0), 1);
    chk("done_ignore_count", 32'(bus.count_ff_o), 50);
    chk("done_ignore_best", 32'(bus.best_energy_ff_o), 51);

    // Start together with a sample: sample dropped.
    drive(1, 1, 5, 0, 0, 0, 0);
    chk("restart_count", 32'(bus.count_ff_o), 0);
    chk("restart_busy", 32'(bus.busy_ff_o), 1);

    // Tie keeps earlier index.
    sample(3, 20);
    sample(7, 20);
    chk("tie_bidx", 32'(bus.best_idx_ff_o), 3);
    chk("tie_best", 32'(bus.best_energy_ff_o), 20);

    // Duplicate and out-of-range.
    sample(5, 30);
    sample(5, 10);
    sample(60, 1);
    chk("dup_count", 32'(bus.count_ff_o), 3);
    chk("dup_err", 32'(bus.err_ff_o), 3);
    rd(5);
    chk("dup_rd5", 32'(bus.rd_data_ff_o), 10);

    // Read and write of the same index in one cycle.
    sample(9, 12);
    drive(0, 1, 44, 9, 1, 9, 0);
    chk("rw_old", 32'(bus.rd_data_ff_o), 12);
    rd(9);
    chk("rw_new", 32'(bus.rd_data_ff_o), 44);
    rd(60);
    chk("rd_oor", 32'(bus.rd_data_ff_o), 0);
    chk("rd_oor_v", 32'(bus.rd_valid_ff_o), 1);
    rd(20);
    chk("rd_unwritten", 32'(bus.rd_data_ff_o), 0);
    idle();
    chk("rd_valid_drop", 32'(bus.rd_valid_ff_o), 0);

    // Reset mid-generation, then a clean generation.
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) sample(i, 300 + i);
    drive(0, 1, 5, 25, 1, 4, 1);
    chk_reset_vals("midrst");
    rd(4);
    chk("rd_after_rst", 32'(bus.rd_data_ff_o), 0);
    d0 = done_seen;
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = POP - 1; i >= 0; i--) sample(i, 200 + (i % 7));
    chk("g2_count", 32'(bus.count_ff_o), 50);
    chk("g2_best", 32'(bus.best_energy_ff_o), 200);
    chk("g2_bidx", 32'(bus.best_idx_ff_o), 49);
    chk("g2_done", 32'(done_seen - d0), 1);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      logic rs, st, v, re;
      int e, idx, ridx;
      rs   = ($urandom_range(0, 499) == 0);
      st   = (m_phase != 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 399) == 0);
      v    = ($urandom_range(0, 3) != 0);
      idx  = $urandom_range(0, 55);
      e    = $urandom_range(0, 1) ? $urandom_range(0, 1023) : $urandom_range(0, 15);
      re   = $urandom_range(0, 1);
      ridx = $urandom_range(0, 63);
      drive(st, v, e, idx, re, ridx, rs);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
